// File: rtl/gpio_cfg_pkg.sv
// Shared definitions for the GPIO pad-configuration serial chain: word layout,
// loader FSM states and block/bit offset helpers.
package gpio_cfg_pkg;

  localparam int unsigned PAD_CTRL_BITS  = 13;
  localparam int unsigned NUM_IO_DEFAULT = 19;

  // Bit offsets inside one pad control word
  localparam int unsigned CFG_MGMT_EN = 0;
  localparam int unsigned CFG_OEB     = 1;
  localparam int unsigned CFG_HLDH    = 2;
  localparam int unsigned CFG_INP_DIS = 3;
  localparam int unsigned CFG_MOD_SEL = 4;
  localparam int unsigned CFG_AN_EN   = 5;
  localparam int unsigned CFG_AN_SEL  = 6;
  localparam int unsigned CFG_AN_POL  = 7;
  localparam int unsigned CFG_SLOW    = 8;
  localparam int unsigned CFG_TRIP    = 9;
  localparam int unsigned CFG_DM_LSB  = 10;
  localparam int unsigned CFG_DM_MSB  = 12;
  localparam int unsigned CFG_DM_BITS = CFG_DM_MSB - CFG_DM_LSB + 1;

  typedef struct packed {
    logic [CFG_DM_BITS-1:0] dm;
    logic                   trip;
    logic                   slow;
    logic                   an_pol;
    logic                   an_sel;
    logic                   an_en;
    logic                   mod_sel;
    logic                   inp_dis;
    logic                   hldh;
    logic                   oeb;
    logic                   mgmt_en;
  } pad_ctrl_t;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SHIFT  = 2'd1,
    SETTLE = 2'd2,
    LOAD   = 2'd3
  } loader_state_e;

  // Flat cfg_data index of a given bit of block blk
  function automatic int unsigned cfg_offset(input int unsigned blk,
                                             input int unsigned bit_idx);
    return blk * PAD_CTRL_BITS + bit_idx;
  endfunction

endpackage

// File: rtl/gpio_serial_clkgate.sv
// Glitch-free clock gate for the serial chain: enable latch open while the
// source clock is low, ANDed with the clock. Drop-in point for a library ICG.
module gpio_serial_clkgate (
  input  logic serial_clock,
  input  logic resetn,
  input  logic clk_en,
  output logic gated_clock
);

  logic en_latched;

  // Reset closes the gate at once so no pulse survives a mid-load reset
  always_latch begin
    if (!resetn) begin
      en_latched <= 1'b0;
    end else if (!serial_clock) begin
      en_latched <= clk_en;
    end
  end

  assign gated_clock = serial_clock & en_latched;

endmodule

// File: rtl/gpio_serial_loader.sv
// Head of the GPIO pad-configuration chain: shifts NUM_IO*PAD_CTRL_BITS bits
// MSB first on a gated clock, then strobes serial_load_out so all blocks latch.
module gpio_serial_loader #(
  parameter int unsigned NUM_IO        = 19,
  parameter int unsigned PAD_CTRL_BITS = gpio_cfg_pkg::PAD_CTRL_BITS
) (
  input  logic                            serial_clock,
  input  logic                            resetn,
  input  logic                            start,
  input  logic [NUM_IO*PAD_CTRL_BITS-1:0] cfg_data,
  output logic                            busy,
  output logic                            done,
  output logic                            serial_clock_out,
  output logic                            serial_data_out,
  output logic                            serial_load_out
);

  import gpio_cfg_pkg::*;

  localparam int unsigned T_BITS = NUM_IO * PAD_CTRL_BITS;
  localparam int unsigned CNT_W  = $clog2(T_BITS);

  loader_state_e    state_q, state_d;
  logic [CNT_W-1:0] bit_cnt_q, bit_cnt_d;
  logic             clk_en_q, clk_en_d;
  logic             load_q, load_d;
  logic             done_q, done_d;
  logic             busy_q, busy_d;
  logic             data_q, data_d;

  // Next-state and registered-output logic
  always_comb begin
    state_d   = state_q;
    bit_cnt_d = bit_cnt_q;
    clk_en_d  = clk_en_q;
    load_d    = 1'b0;
    done_d    = 1'b0;

    unique case (state_q)
      IDLE: begin
        // start is re-sampled only after the done pulse has retired
        if (start && !done_q) begin
          state_d   = SHIFT;
          bit_cnt_d = CNT_W'(T_BITS - 1);
          clk_en_d  = 1'b1;
        end
      end
      SHIFT: begin
        if (bit_cnt_q == '0) begin
          clk_en_d = 1'b0;
          state_d  = SETTLE;
        end else begin
          bit_cnt_d = bit_cnt_q - CNT_W'(1);
        end
      end
      SETTLE: begin
        load_d  = 1'b1;
        state_d = LOAD;
      end
      LOAD: begin
        done_d  = 1'b1;
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    busy_d = (state_d != IDLE);
    data_d = (state_q == SHIFT) ? cfg_data[bit_cnt_q] : 1'b0;
  end

  always_ff @(posedge serial_clock or negedge resetn) begin
    if (!resetn) begin
      state_q   <= IDLE;
      bit_cnt_q <= '0;
      clk_en_q  <= 1'b0;
      load_q    <= 1'b0;
      done_q    <= 1'b0;
      busy_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      bit_cnt_q <= bit_cnt_d;
      clk_en_q  <= clk_en_d;
      load_q    <= load_d;
      done_q    <= done_d;
      busy_q    <= busy_d;
    end
  end

  // Data launched on the falling edge: half a cycle of setup and hold at the chain
  always_ff @(negedge serial_clock or negedge resetn) begin
    if (!resetn) begin
      data_q <= 1'b0;
    end else begin
      data_q <= data_d;
    end
  end

  gpio_serial_clkgate u_clkgate (
    .serial_clock (serial_clock),
    .resetn       (resetn),
    .clk_en       (clk_en_q),
    .gated_clock  (serial_clock_out)
  );

  assign busy            = busy_q;
  assign done            = done_q;
  assign serial_data_out = data_q;
  assign serial_load_out = load_q;

endmodule

// File: tb/tb_gpio_serial_loader.sv
// Bench for gpio_serial_loader: a 2-block and a 19-block instance, a cycle-offset
// reference model, a two-block chain model and directed load scenarios.
module tb_gpio_serial_loader;

  localparam int T2  = 26;
  localparam int T19 = 247;
  localparam logic [12:0] GPIO_DEFAULT = 13'h0402;

  logic           serial_clock = 1'b0;
  logic           resetn       = 1'b0;
  logic           start_i [2];
  logic [T2-1:0]  cfg2;
  logic [T19-1:0] cfg19;
  logic           busy_o [2];
  logic           done_o [2];
  logic           sco_o  [2];
  logic           sdo_o  [2];
  logic           slo_o  [2];

  gpio_serial_loader #(.NUM_IO(2)) dut2 (
    .serial_clock     (serial_clock),
    .resetn           (resetn),
    .start            (start_i[0]),
    .cfg_data         (cfg2),
    .busy             (busy_o[0]),
    .done             (done_o[0]),
    .serial_clock_out (sco_o[0]),
    .serial_data_out  (sdo_o[0]),
    .serial_load_out  (slo_o[0])
  );

  gpio_serial_loader #(.NUM_IO(19)) dut19 (
    .serial_clock     (serial_clock),
    .resetn           (resetn),
    .start            (start_i[1]),
    .cfg_data         (cfg19),
    .busy             (busy_o[1]),
    .done             (done_o[1]),
    .serial_clock_out (sco_o[1]),
    .serial_data_out  (sdo_o[1]),
    .serial_load_out  (slo_o[1])
  );

  always #5 serial_clock = ~serial_clock;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;

  always @(posedge serial_clock) cyc <= cyc + 1;

  task automatic chk_b(input string name, input logic act, input logic exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %b, required %b (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic chk_i(input string name, input int act, input int exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0d (0x%0h), required %0d (0x%0h) (t=%0t)",
               name, act, act, exp, exp, $time);
    end
  endtask

  function automatic int tlen(input int i);
    return (i == 0) ? T2 : T19;
  endfunction

  // Reference model: mj = cycles since the accepting edge c0 (-1 when idle)
  int mj    [2] = '{-1, -1};
  bit mdone [2] = '{1'b0, 1'b0};

  always @(posedge serial_clock or negedge resetn) begin
    if (!resetn) begin
      for (int i = 0; i < 2; i++) begin
        mj[i]    <= -1;
        mdone[i] <= 1'b0;
      end
    end else begin
      for (int i = 0; i < 2; i++) begin
        if (mj[i] < 0) begin
          if (start_i[i] === 1'b1 && !mdone[i]) mj[i] <= 0;
          mdone[i] <= 1'b0;
        end else if (mj[i] == tlen(i) + 1) begin
          mj[i]    <= -1;
          mdone[i] <= 1'b1;
        end else begin
          mj[i] <= mj[i] + 1;
        end
      end
    end
  end

  // Bit presented to the chain during the cycle after edge c_j is cfg[T-1-j]
  function automatic logic exp_data(input int i);
    int j;
    j = mj[i];
    if (j < 0 || j >= tlen(i)) return 1'b0;
    if (i == 0) return cfg2[T2-1-j];
    return cfg19[T19-1-j];
  endfunction

  initial begin : compare
    forever begin
      @(posedge serial_clock); #2;
      for (int i = 0; i < 2; i++) begin
        chk_b($sformatf("busy%0d", i), busy_o[i], mj[i] >= 0);
        chk_b($sformatf("done%0d", i), done_o[i], mdone[i]);
        chk_b($sformatf("load%0d", i), slo_o[i], mj[i] == tlen(i) + 1);
        chk_b($sformatf("gclk_hi%0d", i), sco_o[i], mj[i] >= 1 && mj[i] <= tlen(i));
      end
      @(negedge serial_clock); #2;
      for (int i = 0; i < 2; i++) begin
        chk_b($sformatf("data%0d", i), sdo_o[i], exp_data(i));
        chk_b($sformatf("gclk_lo%0d", i), sco_o[i], 1'b0);
      end
    end
  end

  // Two-block chain model driven by dut2
  logic [T2-1:0] chain_sr;
  logic [12:0]   blk [2];
  always @(posedge sco_o[0] or negedge resetn) begin
    if (!resetn) chain_sr <= '0;
    else         chain_sr <= {chain_sr[T2-2:0], sdo_o[0]};
  end
  always @(posedge slo_o[0] or negedge resetn) begin
    if (!resetn) begin
      blk[0] <= GPIO_DEFAULT;
      blk[1] <= GPIO_DEFAULT;
    end else begin
      blk[0] <= chain_sr[12:0];
      blk[1] <= chain_sr[25:13];
    end
  end

  // Edge counters, captured serial stream and data-edge timing watch
  int            edges2  = 0;
  int            edges19 = 0;
  int            loads2  = 0;
  int            viol    = 0;
  logic [T2-1:0] cap2    = '0;
  longint        last_chg  = -100;
  longint        last_edge = -100;

  always @(posedge sco_o[0]) begin
    edges2 <= edges2 + 1;
    cap2   <= {cap2[T2-2:0], sdo_o[0]};
  end
  always @(posedge sco_o[1]) edges19 <= edges19 + 1;
  always @(posedge slo_o[0]) loads2  <= loads2 + 1;

  always @(posedge sco_o[0]) begin : setup_watch
    if (resetn && (longint'($time) - last_chg) < 4) viol++;
    last_edge = longint'($time);
  end
  always @(sdo_o[0]) begin : hold_watch
    if (resetn && (longint'($time) - last_edge) < 4) viol++;
    last_chg = longint'($time);
  end

  task automatic tick();
    @(posedge serial_clock); #1;
  endtask

  task automatic run_load(input int i, input int c0, input int cycles,
                          output int load_off, output int done_off, output int ndone);
    load_off = -1;
    done_off = -1;
    ndone    = 0;
    repeat (cycles) begin
      @(posedge serial_clock); #2;
      if (slo_o[i] && load_off < 0) load_off = cyc - c0;
      if (done_o[i]) begin
        ndone++;
        if (done_off < 0) done_off = cyc - c0;
      end
    end
  endtask

  initial begin : stim
    int c0, e0, l0, v0, lo, dn, nd, n, low;
    int doffs [3];

    // Reset held with start asserted
    start_i[0] = 1'b1;
    start_i[1] = 1'b1;
    cfg2  = {13'h1803, 13'h0403};
    cfg19 = {19{13'h15A3}};
    repeat (3) tick();
    chk_b("rst_busy", busy_o[0], 1'b0);
    chk_b("rst_done", done_o[1], 1'b0);
    chk_b("rst_load", slo_o[0], 1'b0);
    chk_i("rst_edges", edges2 + edges19, 0);
    start_i[0] = 1'b0;
    start_i[1] = 1'b0;
    tick();
    resetn = 1'b1;
    tick();

    // Single load of {1803,0403}
    e0 = edges2; l0 = loads2; v0 = viol;
    start_i[0] = 1'b1;
    c0 = cyc + 1;
    tick();
    start_i[0] = 1'b0;
    run_load(0, c0, 35, lo, dn, nd);
    chk_i("a_edges", edges2 - e0, 26);
    chk_i("a_stream", int'(cap2), int'({13'h1803, 13'h0403}));
    chk_i("a_load_cycle", lo, 27);
    chk_i("a_done_cycle", dn, 28);
    chk_i("a_done_count", nd, 1);
    chk_i("a_load_pulses", loads2 - l0, 1);
    chk_i("a_blk0", int'(blk[0]), int'(13'h0403));
    chk_i("a_blk1", int'(blk[1]), int'(13'h1803));
    chk_i("a_data_timing", viol - v0, 0);

    // start re-pulsed at c10 is ignored
    cfg2 = {13'h0ABC, 13'h1555};
    e0 = edges2; l0 = loads2;
    start_i[0] = 1'b1;
    c0 = cyc + 1;
    tick();
    start_i[0] = 1'b0;
    repeat (9) tick();
    start_i[0] = 1'b1;
    tick();
    start_i[0] = 1'b0;
    run_load(0, c0, 30, lo, dn, nd);
    chk_i("b_edges", edges2 - e0, 26);
    chk_i("b_done_cycle", dn, 28);
    chk_i("b_done_count", nd, 1);
    chk_i("b_load_pulses", loads2 - l0, 1);
    chk_i("b_blk0", int'(blk[0]), int'(13'h1555));
    chk_i("b_blk1", int'(blk[1]), int'(13'h0ABC));

    // resetn pulsed low at c15 of SHIFT
    cfg2 = {13'h1F0F, 13'h00F1};
    e0 = edges2; l0 = loads2;
    start_i[0] = 1'b1;
    c0 = cyc + 1;
    tick();
    start_i[0] = 1'b0;
    repeat (15) tick();
    resetn = 1'b0;
    #1;
    chk_b("c_rst_busy", busy_o[0], 1'b0);
    chk_b("c_rst_gclk", sco_o[0], 1'b0);
    chk_b("c_rst_data", sdo_o[0], 1'b0);
    chk_i("c_partial_edges", edges2 - e0, 15);
    repeat (2) tick();
    resetn = 1'b1;
    tick();
    chk_i("c_no_load", loads2 - l0, 0);
    chk_i("c_blk0_default", int'(blk[0]), int'(GPIO_DEFAULT));
    chk_i("c_blk1_default", int'(blk[1]), int'(GPIO_DEFAULT));
    e0 = edges2; v0 = viol;
    start_i[0] = 1'b1;
    c0 = cyc + 1;
    tick();
    start_i[0] = 1'b0;
    run_load(0, c0, 35, lo, dn, nd);
    chk_i("c_edges", edges2 - e0, 26);
    chk_i("c_done_cycle", dn, 28);
    chk_i("c_blk0", int'(blk[0]), int'(13'h00F1));
    chk_i("c_blk1", int'(blk[1]), int'(13'h1F0F));
    chk_i("c_data_timing", viol - v0, 0);

    // start held high on the 19-block instance: three back-to-back loads
    e0 = edges19;
    doffs = '{-1, -1, -1};
    n = 0;
    low = 0;
    start_i[1] = 1'b1;
    c0 = cyc + 1;
    for (int k = 0; k < 900 && n < 3; k++) begin
      @(posedge serial_clock); #2;
      if (done_o[1]) begin
        doffs[n] = cyc - c0;
        n++;
      end
      if (n < 3 && !busy_o[1]) low++;
    end
    start_i[1] = 1'b0;
    repeat (3) tick();
    chk_i("d_done_seen", n, 3);
    chk_i("d_done0", doffs[0], 249);
    chk_i("d_done1", doffs[1], 500);
    chk_i("d_done2", doffs[2], 751);
    chk_i("d_edges", edges19 - e0, 3 * T19);
    chk_i("d_busy_low_cycles", low, 4);
    chk_b("d_idle_after", busy_o[1], 1'b0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
